// File: rtl/wb_pwm_seq_pkg.sv
// Shared definitions for the Wishbone PWM fade sequencer: field widths, FSM states
// and the tick-divider ratio helper.
package wb_pwm_seq_pkg;

    localparam int ADR_W  = 4;
    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_REQ  = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    // Degenerate parameterisations (unset rates, step faster than clock) tick every cycle.
    function automatic int tick_div(input int clk_hz, input int step_hz);
        if (step_hz <= 0 || clk_hz < step_hz) begin
            return 1;
        end
        return clk_hz / step_hz;
    endfunction

endpackage

// File: rtl/wb_pwm_seq_tick.sv
// Fade step divider: one-cycle tick_o every WB_CLK_HZ/STEP_HZ clocks, counting from reset.
// Free-running, no backpressure.
module wb_pwm_seq_tick
    import wb_pwm_seq_pkg::*;
#(
    parameter int WB_CLK_HZ = 0,
    parameter int STEP_HZ   = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int            DIV  = tick_div(WB_CLK_HZ, STEP_HZ);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == LAST);
        cnt_d  = tick_o ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_pwm_seq.sv
// PWM fade sequencer: steps each channel's duty one unit toward its target per tick via a
// Wishbone master; slave acks after one cycle, never stalls; WB_PWM_SEQ_READBACK_EN adds reads.
module wb_pwm_seq
    import wb_pwm_seq_pkg::*;
#(
    parameter int WB_CLK_HZ   = 0,
    parameter int STEP_HZ     = 0,
    parameter int CHANNEL_NUM = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADR_W-1:0]  wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_stall_o,
    output logic              wb_ack_o,
    output logic              pwm_cyc_o,
    output logic              pwm_stb_o,
    output logic              pwm_we_o,
    output logic [ADR_W-1:0]  pwm_adr_o,
    output logic [31:0]       pwm_dat_o,
    input  logic              pwm_stall_i,
    input  logic              pwm_ack_i,
    output logic              busy_o
);

    localparam logic [ADR_W-1:0] LAST_IDX = ADR_W'(CHANNEL_NUM - 1);

    logic [DUTY_W-1:0] cur_q [CHANNEL_NUM];
    logic [DUTY_W-1:0] tgt_q [CHANNEL_NUM];
    state_e            state_q, state_d;
    logic [ADR_W-1:0]  idx_q, idx_d;
    logic [DUTY_W-1:0] nxt_q, nxt_d;
    logic              pending_q, pending_d;
    logic              ack_q;
    logic              tick;
    logic              slv_req, slv_wr, cur_upd;
    logic [DUTY_W-1:0] cur_sel, tgt_sel;
    logic              unused_dat_hi;

    wb_pwm_seq_tick #(
        .WB_CLK_HZ (WB_CLK_HZ),
        .STEP_HZ   (STEP_HZ)
    ) u_tick (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .tick_o (tick)
    );

    assign slv_req       = wb_cyc_i & wb_stb_i;
    assign slv_wr        = slv_req & wb_we_i;
    assign wb_stall_o    = 1'b0;
    assign wb_ack_o      = ack_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign unused_dat_hi = ^wb_dat_i[31:DUTY_W];

    always_comb begin
        cur_sel = '0;
        tgt_sel = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (idx_q == ADR_W'(i)) begin
                cur_sel = cur_q[i];
                tgt_sel = tgt_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nxt_d     = nxt_q;
        pending_d = pending_q;
        cur_upd   = 1'b0;
        pwm_cyc_o = 1'b0;
        pwm_stb_o = 1'b0;
        pwm_we_o  = 1'b0;
        pwm_adr_o = '0;
        pwm_dat_o = '0;

        // A tick that lands while a step is already pending is simply absorbed.
        if (tick) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    idx_d     = '0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cur_sel == tgt_sel) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + ADR_W'(1);
                    end
                end else begin
                    nxt_d   = (cur_sel < tgt_sel) ? cur_sel + DUTY_W'(1) : cur_sel - DUTY_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                pwm_cyc_o = 1'b1;
                pwm_stb_o = 1'b1;
                pwm_we_o  = 1'b1;
                pwm_adr_o = idx_q;
                pwm_dat_o = {{(32-DUTY_W){1'b0}}, nxt_q};
                if (!pwm_stall_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                pwm_cyc_o = 1'b1;
                if (pwm_ack_i) begin
                    cur_upd = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + ADR_W'(1);
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            nxt_q     <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                cur_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            nxt_q     <= nxt_d;
            pending_q <= pending_d;
            ack_q     <= slv_req;
            // Target writes and step commits are independent, so both land in one cycle.
            for (int i = 0; i < CHANNEL_NUM; i++) begin
                if (slv_wr && wb_adr_i == ADR_W'(i)) begin
                    tgt_q[i] <= wb_dat_i[DUTY_W-1:0];
                end
                if (cur_upd && idx_q == ADR_W'(i)) begin
                    cur_q[i] <= nxt_q;
                end
            end
        end
    end

`ifdef WB_PWM_SEQ_READBACK_EN
    logic [31:0] rd_mux, dat_q;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (wb_adr_i == ADR_W'(i)) begin
                rd_mux = {16'b0, tgt_q[i], cur_q[i]};
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            dat_q <= '0;
        end else begin
            dat_q <= (slv_req && !wb_we_i) ? rd_mux : '0;
        end
    end

    assign wb_dat_o = dat_q;
`else
    assign wb_dat_o = '0;
`endif

endmodule

// File: doc/wb_pwm_seq.md
WB_PWM_SEQ -- requirements
Module: wb_pwm_seq

Interface
REQ-001 SHALL have parameter WB_CLK_HZ, default 0: input clock frequency in Hz.
REQ-002 SHALL have parameter STEP_HZ, default 0: fade step rate in Hz, one unit per channel per step.
REQ-003 SHALL have parameter CHANNEL_NUM, default 1: channels sequenced; legal range 1..16.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port wb_clk_i  in  1: single clock.
REQ-006 SHALL have port wb_rst_ni  in  1: asynchronous active-low reset.
REQ-007 SHALL have slave ports wb_cyc_i, wb_stb_i, wb_we_i  in  1 each: Wishbone B4 pipelined request.
REQ-008 SHALL have slave ports wb_adr_i  in  4, wb_dat_i  in  32, wb_dat_o  out  32, wb_stall_o  out  1, wb_ack_o  out  1.
REQ-009 SHALL have master ports pwm_cyc_o, pwm_stb_o, pwm_we_o  out  1 each: Wishbone master toward the PWM block.
REQ-010 SHALL have master ports pwm_adr_o  out  4, pwm_dat_o  out  32, pwm_stall_i  in  1, pwm_ack_i  in  1.
REQ-011 SHALL have port busy_o  out  1: high while a sweep is in progress.

Function
REQ-012 Slave: wb_stall_o SHALL be constant 0; wb_ack_o SHALL pulse one cycle after each cycle with wb_cyc_i & wb_stb_i.
REQ-013 Slave write with adr < CHANNEL_NUM SHALL set tgt[adr] = wb_dat_i[7:0]; writes with adr >= CHANNEL_NUM SHALL be acked and ignored.
REQ-014 The tick divider SHALL emit a one-cycle tick every WB_CLK_HZ/STEP_HZ clocks.
REQ-015 A tick SHALL set the pending flag; ticks arriving while pending is set SHALL be dropped, not queued.
REQ-016 The FSM SHALL have the states IDLE, SCAN, REQ and WAIT.
REQ-017 IDLE: when pending is set, the FSM SHALL clear pending, set idx = 0 and go to SCAN.
REQ-018 SCAN: if cur[idx] == tgt[idx], the FSM SHALL increment idx; otherwise it SHALL latch nxt = cur ± 1 toward tgt and go to REQ.
REQ-019 SCAN: after idx = CHANNEL_NUM-1 is handled with no request, the FSM SHALL return to IDLE.
REQ-020 REQ: the FSM SHALL drive pwm_cyc_o = pwm_stb_o = pwm_we_o = 1, pwm_adr_o = idx and pwm_dat_o = {24'b0, nxt}.
REQ-021 REQ: all master outputs SHALL be held while pwm_stall_i = 1; the first cycle with pwm_stall_i = 0 SHALL go to WAIT.
REQ-022 WAIT: the FSM SHALL hold pwm_stb_o = 0 and pwm_cyc_o = 1 until pwm_ack_i, then set cur[idx] = nxt and pwm_cyc_o = 0.
REQ-023 WAIT: after the ack, the FSM SHALL go to SCAN with idx + 1, or to IDLE if idx was the last channel.
REQ-024 Each sweep SHALL move each channel by at most one unit, so cur never wraps at 0 or 255.
REQ-025 A channel with cur == tgt SHALL generate no bus cycle.
REQ-026 A tgt write during a sweep SHALL take effect when that channel is next scanned and SHALL not abort an in-flight write.
REQ-027 A slave write and a master ack to the same channel in the same cycle SHALL both take effect (tgt from the write, cur from the ack).
REQ-028 busy_o SHALL be 1 exactly when the FSM state != IDLE.

Reset
REQ-029 Assertion of wb_rst_ni = 0 SHALL immediately force all cur and tgt to 0, idx, pending and the divider to 0, and the FSM to IDLE.
REQ-030 During reset all master outputs, wb_ack_o, wb_dat_o and busy_o SHALL be 0.
REQ-031 Reset during REQ/WAIT SHALL abandon the cycle; a late pwm_ack_i SHALL be ignored.

Configuration
REQ-032 With WB_PWM_SEQ_READBACK_EN defined, a slave read of adr < CHANNEL_NUM SHALL return {16'b0, tgt, cur} on wb_dat_o with the ack; other addresses SHALL return 0.
REQ-033 Without WB_PWM_SEQ_READBACK_EN, wb_dat_o SHALL be constant 0 and the read mux SHALL be absent.

Structure
REQ-034 A shared package SHALL hold the FSM state encodings, the address width (4) and the duty width (8).
REQ-035 The tick divider SHALL be the sub-module wb_pwm_seq_tick (parameters WB_CLK_HZ, STEP_HZ; output tick).

Verification (WB_CLK_HZ=1000, STEP_HZ=100, CHANNEL_NUM=4)
REQ-036 Write tgt[1] = 3, no stall, ack after 1 cycle -> exactly three master writes (adr 1, dat 1/2/3), one per tick, 10 clocks apart; then no further cycles.
REQ-037 tgt[0] = 2 and tgt[3] = 1 in the same tick window -> within one sweep, writes adr 0 dat 1 then adr 3 dat 1, with busy_o high throughout.
REQ-038 pwm_stall_i held high for 5 cycles during REQ -> adr/dat/stb stable for all 5 cycles; exactly one transfer, and cur updates only on ack.
REQ-039 Ramp cur[2] to 5, then write tgt[2] = 0 -> writes dat 4,3,2,1,0 on successive ticks; no write below 0.
REQ-040 Assert wb_rst_ni low during WAIT, then release -> outputs 0 immediately, late ack ignored, and readback (with macro) of adr 2 = 0.
REQ-041 Slave write to adr 9 -> acked next cycle; no state change and no master cycle.
